// File: rtl/rat_int_pkg.sv
// Shared definitions for the RAT MCU interrupt controller: register offsets,
// the "no source" ID code and the register-select enum used by the bus decode.
package rat_int_pkg;

  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_ID   = 2'd2;
  localparam logic [1:0] OFS_MODE = 2'd3;

  localparam logic [7:0] ID_NONE = 8'hFF;

  typedef enum logic [1:0] {
    SelMask = OFS_MASK,
    SelPend = OFS_PEND,
    SelId   = OFS_ID,
    SelMode = OFS_MODE
  } reg_sel_t;

endpackage

// File: rtl/rat_irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, or ID_NONE.
module rat_irq_prio_enc
  import rat_int_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [7:0]         id_o,
  output logic               valid_o
);

  always_comb begin
    id_o    = ID_NONE;
    valid_o = 1'b0;
    // Ascending scan that latches the first hit gives index 0 top priority.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && !valid_o) begin
        id_o    = 8'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// Port-mapped interrupt controller: per-source edge/level latching, masking and
// priority encoding onto the single MCU interrupt input.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter logic [7:0]  BASE_ID = 8'hF0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         RD_DATA,
  output logic               RD_SEL,
  output logic               INT
);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] active;

  reg_sel_t   sel;
  logic       hit;
  logic       wr_mask;
  logic       wr_pend;
  logic       wr_mode;
  logic [7:0] id;
  logic       id_valid;

  // BASE_ID is 4-aligned, so the upper six bits pick the block.
  assign hit     = (PORT_ID[7:2] == BASE_ID[7:2]);
  assign sel     = reg_sel_t'(PORT_ID[1:0]);
  assign wr_mask = IO_STRB && hit && (sel == SelMask);
  assign wr_pend = IO_STRB && hit && (sel == SelPend);
  assign wr_mode = IO_STRB && hit && (sel == SelMode);

  assign rise   = IRQ_IN & ~irq_q;
  assign w1c    = wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0;
  assign active = pend_q & mask_q;

  // Edge sources: set beats W1C in the same cycle. Level sources track the input.
  always_comb begin
    pend_d = (mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & IRQ_IN);
  end

  always_ff @(posedge CLK) begin
    // Loaded during reset too, so an input already high at release is not an edge.
    irq_q <= IRQ_IN;
    if (RESET) begin
      mask_q <= '0;
      mode_q <= '1;
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_mask) mask_q <= OUT_PORT[NUM_SRC-1:0];
      if (wr_mode) mode_q <= OUT_PORT[NUM_SRC-1:0];
    end
  end

  rat_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req_i   (active),
    .id_o    (id),
    .valid_o (id_valid)
  );

  assign INT    = id_valid;
  assign RD_SEL = hit;

  always_comb begin
    RD_DATA = 8'h00;
    if (hit) begin
      unique case (sel)
        SelMask: RD_DATA[NUM_SRC-1:0] = mask_q;
        SelPend: RD_DATA[NUM_SRC-1:0] = pend_q;
        SelId:   RD_DATA              = id;
        SelMode: RD_DATA[NUM_SRC-1:0] = mode_q;
        default: RD_DATA              = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed, table-driven bench for rat_int_ctrl (8-source and 3-source instances).
module tb_rat_int_ctrl;

  logic       CLK;
  logic       RESET;
  logic [7:0] IRQ_IN;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] RD_DATA;
  logic       RD_SEL;
  logic       INT;
  logic [7:0] RD_DATA3;
  logic       RD_SEL3;
  logic       INT3;

  int errors = 0;
  int checks = 0;

  rat_int_ctrl #(
    .NUM_SRC (8),
    .BASE_ID (8'hF0)
  ) u_dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ_IN   (IRQ_IN),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .RD_DATA  (RD_DATA),
    .RD_SEL   (RD_SEL),
    .INT      (INT)
  );

  rat_int_ctrl #(
    .NUM_SRC (3),
    .BASE_ID (8'hF0)
  ) u_dut3 (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ_IN   (IRQ_IN[2:0]),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .RD_DATA  (RD_DATA3),
    .RD_SEL   (RD_SEL3),
    .INT      (INT3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] irq;
    logic       wr;
    logic [7:0] wr_port;
    logic [7:0] wr_data;
    logic [7:0] rd_port;
    logic [7:0] exp_rd;
    logic       exp_sel;
    logic       exp_int;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [7:0] irq, input logic wr, input logic [7:0] wr_port,
                              input logic [7:0] wr_data, input logic [7:0] rd_port,
                              input logic [7:0] exp_rd, input logic exp_sel,
                              input logic exp_int);
    vec_t t;
    t.irq = irq; t.wr = wr; t.wr_port = wr_port; t.wr_data = wr_data;
    t.rd_port = rd_port; t.exp_rd = exp_rd; t.exp_sel = exp_sel; t.exp_int = exp_int;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One clock: drive inputs (and optional write), then read rd_port after the edge.
  task automatic apply(input vec_t t, input string name);
    IRQ_IN   = t.irq;
    PORT_ID  = t.wr ? t.wr_port : t.rd_port;
    OUT_PORT = t.wr_data;
    IO_STRB  = t.wr;
    @(posedge CLK);
    #1;
    IO_STRB = 1'b0;
    PORT_ID = t.rd_port;
    #1;
    check({name, ".rd_data"}, RD_DATA, t.exp_rd);
    check({name, ".rd_sel"}, {7'd0, RD_SEL}, {7'd0, t.exp_sel});
    check({name, ".int"}, {7'd0, INT}, {7'd0, t.exp_int});
  endtask

  initial begin
    RESET = 1'b1; IRQ_IN = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;

    //            irq    wr    wport  wdata  rport  exp    sel   int
    vecs[0]  = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 1'b1, 1'b0); // reset MASK
    vecs[1]  = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h00, 1'b1, 1'b0); // reset PEND
    vecs[2]  = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF2, 8'hFF, 1'b1, 1'b0); // reset ID
    vecs[3]  = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF3, 8'hFF, 1'b1, 1'b0); // reset MODE
    vecs[4]  = mk(8'h00, 1'b1, 8'hF0, 8'hFF, 8'hF0, 8'hFF, 1'b1, 1'b0); // MASK=FF
    vecs[5]  = mk(8'h04, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h04, 1'b1, 1'b1); // pulse bit 2
    vecs[6]  = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF2, 8'h02, 1'b1, 1'b1); // stays latched
    vecs[7]  = mk(8'h00, 1'b1, 8'hF1, 8'h04, 8'hF1, 8'h00, 1'b1, 1'b0); // W1C clears
    vecs[8]  = mk(8'h00, 1'b1, 8'hF0, 8'h08, 8'hF0, 8'h08, 1'b1, 1'b0); // MASK=08
    vecs[9]  = mk(8'h0A, 1'b0, 8'h00, 8'h00, 8'hF2, 8'h03, 1'b1, 1'b1); // ID=3
    vecs[10] = mk(8'h00, 1'b1, 8'hF0, 8'h00, 8'hF1, 8'h0A, 1'b1, 1'b0); // MASK=0, PEND kept
    vecs[11] = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF2, 8'hFF, 1'b1, 1'b0); // ID none
    vecs[12] = mk(8'h00, 1'b1, 8'hF0, 8'hFF, 8'hF2, 8'h01, 1'b1, 1'b1); // priority
    vecs[13] = mk(8'h02, 1'b1, 8'hF1, 8'h02, 8'hF1, 8'h0A, 1'b1, 1'b1); // set beats W1C
    vecs[14] = mk(8'h00, 1'b1, 8'hF1, 8'h0A, 8'hF1, 8'h00, 1'b1, 1'b0); // clear all
    vecs[15] = mk(8'h00, 1'b1, 8'hF3, 8'hFE, 8'hF3, 8'hFE, 1'b1, 1'b0); // bit0 level
    vecs[16] = mk(8'h01, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h01, 1'b1, 1'b1); // level high
    vecs[17] = mk(8'h01, 1'b1, 8'hF1, 8'h01, 8'hF1, 8'h01, 1'b1, 1'b1); // W1C no effect
    vecs[18] = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h00, 1'b1, 1'b0); // level falls
    vecs[19] = mk(8'h00, 1'b1, 8'hF2, 8'h55, 8'hF2, 8'hFF, 1'b1, 1'b0); // ID write ignored
    vecs[20] = mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hF4, 8'h00, 1'b0, 1'b0); // out of range

    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Pending request, then reset with a concurrent write and IRQ_IN[5] held high.
    apply(mk(8'h20, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h20, 1'b1, 1'b1), "pre_reset");
    RESET = 1'b1; IO_STRB = 1'b1; PORT_ID = 8'hF0; OUT_PORT = 8'hFF; IRQ_IN = 8'h20;
    @(posedge CLK);
    #1;
    RESET = 1'b0; IO_STRB = 1'b0;
    #1;
    check("rst.mask", RD_DATA, 8'h00);
    check("rst.int", {7'd0, INT}, 8'h00);
    check("rst.int3", {7'd0, INT3}, 8'h00);
    PORT_ID = 8'hF3;
    #1;
    check("rst.mode", RD_DATA, 8'hFF);
    PORT_ID = 8'hF1;
    #1;
    check("rst.pend", RD_DATA, 8'h00);
    apply(mk(8'h20, 1'b0, 8'h00, 8'h00, 8'hF1, 8'h00, 1'b1, 1'b0), "post_rst0");
    apply(mk(8'h20, 1'b1, 8'hF0, 8'hFF, 8'hF1, 8'h00, 1'b1, 1'b0), "post_rst1");

    // Narrow instance: unimplemented bits read 0, ID stays below NUM_SRC.
    PORT_ID = 8'hF0;
    #1;
    check("n3.mask", RD_DATA3, 8'h07);
    apply(mk(8'h24, 1'b0, 8'h00, 8'h00, 8'hF2, 8'h02, 1'b1, 1'b1), "irq24");
    check("n3.id", RD_DATA3, 8'h02);
    check("n3.int", {7'd0, INT3}, 8'h01);
    PORT_ID = 8'hF1;
    #1;
    check("n3.pend", RD_DATA3, 8'h04);
    PORT_ID = 8'hF4;
    #1;
    check("n3.rd_sel", {7'd0, RD_SEL3}, 8'h00);
    check("n3.rd_data", RD_DATA3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
